// File: rtl/render_pkg.sv
// Types and constants shared by the polygon scheduler and the render pipeline.
package render_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLOSE = 2'd2
  } sched_state_t;

  localparam int COORD_W = 32;

  localparam logic [3:0] COLOR_BLACK = 4'd0;
  localparam logic [3:0] COLOR_RED   = 4'd1;
  localparam logic [3:0] COLOR_GREEN = 4'd2;
  localparam logic [3:0] COLOR_BLUE  = 4'd3;
  localparam logic [3:0] COLOR_WHITE = 4'd15;

  // Default palette index render uses for a polygon slot.
  function automatic logic [3:0] slot_colour(input logic [1:0] slot);
    case (slot)
      2'd0:    return COLOR_RED;
      2'd1:    return COLOR_GREEN;
      2'd2:    return COLOR_BLUE;
      2'd3:    return COLOR_WHITE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// advance moves the pointer one past the current grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  int            win_s;
  int            best_d_s;
  int            dist_s;

  // Nearest requester by rotational distance from the pointer
  always_comb begin
    win_s    = 0;
    best_d_s = N;
    dist_s   = 0;
    for (int i = 0; i < N; i++) begin
      dist_s = (i - int'(ptr_r) + N) % N;
      if (req[i] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        win_s    = i;
      end else begin
        best_d_s = best_d_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = (best_d_s < N) && (win_s == i);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance && (best_d_s < N)) begin
      ptr_r <= PW'((win_s + 1) % N);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/polygon_scheduler.sv
// Arbitrates producer vertex bursts into a shadow polygon table and commits
// dirty slots to the registered live table at the last active pixel of a frame.
module polygon_scheduler
  import render_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int NUM_POLYS        = 4,
  parameter int MAX_NUM_VERTICES = 4,
  parameter int PIXEL_WIDTH      = 1280,
  parameter int PIXEL_HEIGHT     = 720
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]                        hcount_in,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]                       vcount_in,
  input  logic [NUM_REQ-1:0]                                    req_in,
  input  logic [NUM_REQ-1:0][$clog2(NUM_POLYS)-1:0]             id_in,
  input  logic [NUM_REQ-1:0][$clog2(MAX_NUM_VERTICES):0]        count_in,
  input  logic [NUM_REQ-1:0][COORD_W-1:0]                       vx_in,
  input  logic [NUM_REQ-1:0][COORD_W-1:0]                       vy_in,
  input  logic [NUM_REQ-1:0]                                    vvalid_in,
  output logic [NUM_REQ-1:0]                                    vready_out,
  output logic [NUM_REQ-1:0]                                    grant_out,
  output logic [NUM_POLYS-1:0][MAX_NUM_VERTICES-1:0][COORD_W-1:0] xs_out,
  output logic [NUM_POLYS-1:0][MAX_NUM_VERTICES-1:0][COORD_W-1:0] ys_out,
  output logic [NUM_POLYS-1:0][$clog2(MAX_NUM_VERTICES):0]      num_points_out,
  output logic [NUM_POLYS-1:0]                                  enable_out,
  output logic                                                  frame_swap_out,
  output logic                                                  busy_out
);

  localparam int HW  = $clog2(PIXEL_WIDTH);
  localparam int VW  = $clog2(PIXEL_HEIGHT);
  localparam int IDW = $clog2(NUM_POLYS);
  localparam int CW  = $clog2(MAX_NUM_VERTICES) + 1;
  localparam int WW  = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [MAX_NUM_VERTICES-1:0][COORD_W-1:0] vert_row_t;

  sched_state_t state_r, state_s;

  logic [NUM_REQ-1:0] grant_r, vready_r;
  logic [NUM_REQ-1:0] arb_req_s, arb_grant_s;
  logic               arb_advance_s;
  logic [PW-1:0]      win_idx_r, arb_idx_s;
  logic [IDW-1:0]     cur_id_r;
  logic [CW-1:0]      cur_cnt_r, req_cnt_s;
  logic [WW-1:0]      widx_r;
  logic               accept_s, last_s, commit_s;
  logic [NUM_POLYS-1:0] hold_s;

  vert_row_t [NUM_POLYS-1:0]  shadow_x_r, shadow_y_r, live_x_r, live_y_r;
  logic [NUM_POLYS-1:0][CW-1:0] shadow_n_r, live_n_r;
  logic [NUM_POLYS-1:0]       shadow_en_r, live_en_r, dirty_r;
  logic                       frame_swap_r;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
    if (c > CW'(MAX_NUM_VERTICES)) begin
      return CW'(MAX_NUM_VERTICES);
    end else begin
      return c;
    end
  endfunction

  // Outside IDLE the arbiter sees only the winner, so advance skips exactly it.
  assign arb_req_s     = (state_r == IDLE) ? req_in : grant_r;
  assign arb_advance_s = (state_r == CLOSE);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .req     (arb_req_s),
    .advance (arb_advance_s),
    .grant   (arb_grant_s)
  );

  // One-hot grant to producer index
  always_comb begin
    arb_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant_s[i]) begin
        arb_idx_s = PW'(i);
      end else begin
        arb_idx_s = arb_idx_s;
      end
    end
  end

  assign req_cnt_s = count_in[arb_idx_s];
  assign last_s    = (CW'(widx_r) == (cur_cnt_r - CW'(1)));
  assign commit_s  = (vcount_in == VW'(PIXEL_HEIGHT - 1)) && (hcount_in == HW'(PIXEL_WIDTH - 1));

  // A slot being loaded is never copied, even if an older burst left it dirty
  always_comb begin
    for (int i = 0; i < NUM_POLYS; i++) begin
      hold_s[i] = (state_r != IDLE) && (cur_id_r == IDW'(i));
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and vertex-accept logic
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_in) begin
          if (req_cnt_s < CW'(3)) begin
            state_s = CLOSE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        accept_s = vvalid_in[win_idx_r] & vready_r[win_idx_r];
        if (accept_s && last_s) begin
          state_s = CLOSE;
        end else begin
          state_s = LOAD;
        end
      end
      CLOSE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Burst bookkeeping, shadow writes, dirty tracking and frame commit
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      grant_r      <= '0;
      vready_r     <= '0;
      win_idx_r    <= '0;
      cur_id_r     <= '0;
      cur_cnt_r    <= '0;
      widx_r       <= '0;
      shadow_x_r   <= '0;
      shadow_y_r   <= '0;
      shadow_n_r   <= '0;
      shadow_en_r  <= '0;
      dirty_r      <= '0;
      live_x_r     <= '0;
      live_y_r     <= '0;
      live_n_r     <= '0;
      live_en_r    <= '0;
      frame_swap_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_in) begin
            grant_r   <= arb_grant_s;
            vready_r  <= (req_cnt_s < CW'(3)) ? '0 : arb_grant_s;
            win_idx_r <= arb_idx_s;
            cur_id_r  <= id_in[arb_idx_s];
            cur_cnt_r <= clamp_cnt(req_cnt_s);
            widx_r    <= '0;
          end
        end
        LOAD: begin
          if (accept_s) begin
            shadow_x_r[cur_id_r][widx_r] <= vx_in[win_idx_r];
            shadow_y_r[cur_id_r][widx_r] <= vy_in[win_idx_r];
            widx_r <= widx_r + WW'(1);
            if (last_s) begin
              vready_r <= '0;
            end
          end
        end
        CLOSE: begin
          shadow_n_r[cur_id_r]  <= cur_cnt_r;
          shadow_en_r[cur_id_r] <= (cur_cnt_r >= CW'(3));
          grant_r  <= '0;
          vready_r <= '0;
          widx_r   <= '0;
        end
        default: begin
        end
      endcase

      frame_swap_r <= commit_s;
      for (int i = 0; i < NUM_POLYS; i++) begin
        if (commit_s && dirty_r[i] && !hold_s[i]) begin
          live_x_r[i]  <= shadow_x_r[i];
          live_y_r[i]  <= shadow_y_r[i];
          live_n_r[i]  <= shadow_n_r[i];
          live_en_r[i] <= shadow_en_r[i];
          dirty_r[i]   <= 1'b0;
        end
        if ((state_r == CLOSE) && (cur_id_r == IDW'(i))) begin
          dirty_r[i] <= 1'b1;
        end
      end
    end
  end

  assign grant_out      = grant_r;
  assign vready_out     = vready_r;
  assign xs_out         = live_x_r;
  assign ys_out         = live_y_r;
  assign num_points_out = live_n_r;
  assign enable_out     = live_en_r;
  assign frame_swap_out = frame_swap_r;
  assign busy_out       = (state_r != IDLE);

endmodule

// File: doc/polygon_scheduler.md
# polygon_scheduler

Loads polygon vertex lists from several producers (car physics, terrain generator, ...) into a bank of polygon slots that feed the `draw_polygon` instances in `render`. A round-robin arbiter grants one producer at a time a burst write into a shadow vertex table. Dirty slots are committed to the live table once per frame, at the start of vertical blanking, so the pixel pipeline never sees a half-written polygon.

## Interface
- `NUM_REQ`, 2, number of producers
- `NUM_POLYS`, 4, number of polygon slots
- `MAX_NUM_VERTICES`, 4, vertices per slot
- `PIXEL_WIDTH`, 1280, active pixels per line
- `PIXEL_HEIGHT`, 720, active lines per frame
- `clk_in`  in  1  pixel clock; single clock domain
- `rst_in`  in  1  reset, synchronous, active-low
- `hcount_in`  in  $clog2(PIXEL_WIDTH)  current pixel x
- `vcount_in`  in  $clog2(PIXEL_HEIGHT)  current pixel y
- `req_in`  in  [NUM_REQ]  producer requests a burst; held until granted
- `id_in`  in  [NUM_REQ][$clog2(NUM_POLYS)]  target slot; stable while `req_in` is high
- `count_in`  in  [NUM_REQ][$clog2(MAX_NUM_VERTICES)+1]  vertex count; stable while `req_in` is high
- `vx_in`, `vy_in`  in  [NUM_REQ] signed 32  vertex coordinates, world units
- `vvalid_in`  in  [NUM_REQ]  vertex valid
- `vready_out`  out  [NUM_REQ]  vertex ready; only the granted producer's bit is ever high
- `grant_out`  out  [NUM_REQ]  one-hot grant, high for the whole burst
- `xs_out`, `ys_out`  out  [NUM_POLYS][MAX_NUM_VERTICES] signed 32  live vertex table
- `num_points_out`  out  [NUM_POLYS][$clog2(MAX_NUM_VERTICES)+1]  live vertex counts
- `enable_out`  out  [NUM_POLYS]  slot is drawn
- `frame_swap_out`  out  1  one-cycle pulse on commit
- `busy_out`  out  1  a burst is in progress

## Operation
- FSM with three states.
- **IDLE**
  - If any `req_in` bit is set: pick the winner round-robin, starting at the producer after the last one served.
  - Latch its `id_in` and `count_in` into `cur_id` and `cur_cnt`.
  - Set `grant_out` and go to LOAD.
  - `cur_cnt` greater than MAX_NUM_VERTICES is clamped to MAX_NUM_VERTICES.
  - If `count_in` < 3, go to CLOSE with no vertices accepted.
- **LOAD**
  - `vready_out[winner]` is high.
  - Each cycle with `vvalid_in[winner]` high, write the vertex to `shadow[cur_id][widx]` and increment `widx`.
  - When the accepted vertex is number `cur_cnt`, go to CLOSE.
- **CLOSE**
  - Write `shadow_n[cur_id]` = `cur_cnt` and `shadow_en[cur_id]` = (`cur_cnt` ≥ 3).
  - Set `dirty[cur_id]`.
  - Advance the round-robin pointer past the winner, clear `grant_out`, clear `widx`, go to IDLE.
- **Commit**
  - Condition: `vcount_in` == PIXEL_HEIGHT-1 and `hcount_in` == PIXEL_WIDTH-1 (last active pixel).
  - For every slot with `dirty` set: copy the shadow to the live outputs and clear `dirty`.
  - Pulse `frame_swap_out`.
  - Commit is independent of FSM state; an in-flight burst continues untouched and its slot is not yet dirty.
- **Simultaneous events**
  - CLOSE setting `dirty` in the same cycle as commit: the slot commits at the next frame.
  - Two bursts to the same slot in one frame: the last completed burst wins.
- Vertices beyond `count_in` are never requested; stale `shadow` entries beyond the count are don't-care.

## Timing
- Reset (`rst_in`=0 at an edge): state IDLE, pointer at producer 0, `widx`=0, `dirty`=0.
- Reset values of outputs:
  - `grant_out` = 0, `vready_out` = 0
  - `enable_out` = 0, `num_points_out` = 0, `xs_out` = `ys_out` = 0
  - `frame_swap_out` = 0, `busy_out` = 0
- Reset mid-burst abandons the burst; the shadow contents are don't-care.
- `grant_out` and `vready_out` rise one cycle after `req_in` is sampled in IDLE.
- Vertex throughput is one per cycle.
- CLOSE lasts one cycle. The earliest next grant is 2 cycles after the last vertex is accepted.
- `busy_out` = (state != IDLE).
- Live outputs and `frame_swap_out` update on the clock edge after the commit condition. Live outputs are registered and stable for the whole active frame.

## Structure
- `render_pkg` holds:
  - `sched_state_t` enum {IDLE, LOAD, CLOSE}
  - `COORD_W` = 32
  - the colour index constants shared with `render`
- Sub-module `rr_arbiter #(N)`:
  - inputs `req`, `advance`; output one-hot `grant`
  - rotating pointer; `advance` moves the pointer past the current grant.
- Shadow and live tables are flop arrays; no BRAM.

## Test plan
- **Single burst:** producer 0 requests slot 2, count 4, vertices (100,100),(200,100),(200,200),(100,200), `vvalid` continuous -> grant at +1, 4 accepts, busy for 5 cycles; after the next commit `enable_out[2]`=1, `num_points_out[2]`=4, coordinates match.
- **Arbitration:** both producers request continuously -> grants alternate 0,1,0,1; each burst is separated by 2 idle cycles.
- **Stall:** `vvalid` toggles every other cycle during a count-3 burst -> exactly 3 writes, `widx` never skips.
- **Degenerate and oversize counts:**
  - count 2 -> no `vready_out`, burst ends; after commit, `enable_out`=0.
  - count 7 with MAX 4 -> `num_points_out`=4.
- **Commit race:** CLOSE coincides with the commit cycle -> that slot is unchanged this frame and updates at the next commit; a burst spanning the commit edge never shows a partial polygon.
- **Reset mid-LOAD:** `rst_in`=0 for one cycle -> all outputs 0, pointer at 0; no slot committed at the following frame.
